// File: rtl/sr_ff_checker_pkg.sv
// Shared types and constants for the SR flip-flop checker.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    ST_UNINIT   = 2'd0,
    ST_TRACK    = 2'd1,
    ST_HOLD_OFF = 2'd2
  } state_t;

  // {s, r} encodings
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_BAD  = 2'b11;

  localparam int LAT_MAX = 4;

endpackage

// File: rtl/sr_ff_checker_if.sv
// Observation bus between an SR flop under test and its checker.
interface sr_ff_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             s;
  logic             r;
  logic             q;
  logic             exp_q;
  logic             exp_vld;
  logic             mismatch;
  logic             illegal;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic [1:0]       state;

  modport master (
    output en, s, r, q,
    input  exp_q, exp_vld, mismatch, illegal, err_cnt, chk_cnt, state
  );

  modport slave (
    input  en, s, r, q,
    output exp_q, exp_vld, mismatch, illegal, err_cnt, chk_cnt, state
  );
endinterface

// File: rtl/sr_ff_checker_sat_counter.sv
// Saturating event counter with a 0..2 increment; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W:0] MAX = {1'b0, {CNT_W{1'b1}}};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] sum;
    sum = (CNT_W+1)'(a) + (CNT_W+1)'(b);
    return (sum > MAX) ? MAX[CNT_W-1:0] : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= sat_add(cnt, inc);
  end

endmodule

// File: rtl/sr_ff_checker.sv
// Observer for a master-slave SR flop: reference model, LAT-deep expectation
// pipeline, compare/illegal pulses and saturating counters.
// Optional: define SR_FF_CHK_RESYNC_EN to reload the model from q on mismatch.
module sr_ff_checker
  import sr_chk_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int CNT_W = 8
) (
  input logic             clk,
  input logic             rst,
  sr_ff_checker_if.slave  bus
);

`ifdef SR_FF_CHK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic [1:0] sr;
  logic       model_q, known_q;
  logic       model_nx, known_nx;
  state_t     st_q, st_nx;
  logic [1:0] stage_p [LAT];   // {known, model}
  logic       vld_p_last, exp_p_last;
  logic       cmp_act, cmp_bad, ill_nx;
  logic       mis_q, ill_q;
  logic [1:0] err_inc, chk_inc;

  assign sr         = {bus.s, bus.r};
  assign vld_p_last = stage_p[LAT-1][1];
  assign exp_p_last = stage_p[LAT-1][0];
  assign cmp_act    = bus.en && vld_p_last;
  assign cmp_bad    = cmp_act && (bus.q != exp_p_last);
  assign ill_nx     = bus.en && (sr == SR_BAD);

  always_comb begin
    model_nx = model_q;
    known_nx = known_q;
    st_nx    = st_q;
    unique case (sr)
      SR_RST: begin model_nx = 1'b0; known_nx = 1'b1; st_nx = ST_TRACK; end
      SR_SET: begin model_nx = 1'b1; known_nx = 1'b1; st_nx = ST_TRACK; end
      SR_BAD: begin
        known_nx = 1'b0;
        if (st_q == ST_TRACK) st_nx = ST_HOLD_OFF;
      end
      default: ;
    endcase
  end

  // sample stage -> expectation pipeline -> registered compare
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= ST_UNINIT;
      model_q <= 1'b0;
      known_q <= 1'b0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      for (int i = 0; i < LAT; i++) stage_p[i] <= 2'b00;
    end else begin
      mis_q <= cmp_bad;
      ill_q <= ill_nx;
      if (bus.en) begin
        st_q <= st_nx;
        if (RESYNC && cmp_bad) begin
          // Realign on the observed value so one divergence is counted once.
          model_q <= bus.q;
          known_q <= 1'b1;
          for (int i = 0; i < LAT; i++) stage_p[i] <= {1'b1, bus.q};
        end else begin
          model_q    <= model_nx;
          known_q    <= known_nx;
          stage_p[0] <= {known_nx, model_nx};
          for (int i = 1; i < LAT; i++) stage_p[i] <= stage_p[i-1];
        end
      end
    end
  end

  assign err_inc = {1'b0, cmp_bad} + {1'b0, ill_nx};
  assign chk_inc = {1'b0, cmp_act};

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .cnt (bus.err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_chk_cnt (
    .clk (clk),
    .rst (rst),
    .inc (chk_inc),
    .cnt (bus.chk_cnt)
  );

  assign bus.exp_q    = exp_p_last;
  assign bus.exp_vld  = vld_p_last;
  assign bus.mismatch = mis_q;
  assign bus.illegal  = ill_q;
  assign bus.state    = st_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Randomized bench for sr_ff_checker: two instances (LAT=1/CNT_W=8 and
// LAT=3/CNT_W=2) checked every cycle against a history-based reference model.
`timescale 1ns/1ps
module tb_sr_ff_checker;

`ifdef SR_FF_CHK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_ff_checker_if #(.CNT_W(8)) bus_a ();
  sr_ff_checker_if #(.CNT_W(2)) bus_b ();

  sr_ff_checker #(.LAT(1), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
  sr_ff_checker #(.LAT(3), .CNT_W(2)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  // stimulus
  bit t_rst, t_en, t_s, t_r;
  bit t_q [2];

  // reference model: value history per enabled edge
  bit       m_model [2];
  bit       m_known [2];
  bit [1:0] hist [2][8];
  int       wp [2];
  int       m_state [2];
  bit       m_mis [2];
  bit       m_ill [2];
  int       m_err [2];
  int       m_chk [2];

  int n_chk = 0;
  int n_fail = 0;

  function automatic bit [1:0] exp_pair(input int i);
    int lat;
    lat = (i == 0) ? 1 : 3;
    return hist[i][(wp[i] - lat) & 7];
  endfunction

  task automatic drive();
    rst = t_rst;
    bus_a.en = t_en; bus_a.s = t_s; bus_a.r = t_r; bus_a.q = t_q[0];
    bus_b.en = t_en; bus_b.s = t_s; bus_b.r = t_r; bus_b.q = t_q[1];
  endtask

  task automatic set_in(input bit rv, input bit ev, input bit sv, input bit rrv,
                        input bit q0, input bit q1);
    t_rst = rv; t_en = ev; t_s = sv; t_r = rrv; t_q[0] = q0; t_q[1] = q1;
    drive();
  endtask

  task automatic model_edge(input int i);
    bit [1:0] cur;
    bit mis, ill;
    int mx;
    mx = (i == 0) ? 255 : 3;
    if (t_rst) begin
      m_model[i] = 0; m_known[i] = 0; wp[i] = 0; m_state[i] = 0;
      m_mis[i] = 0; m_ill[i] = 0; m_err[i] = 0; m_chk[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = 2'b00;
      return;
    end
    m_mis[i] = 0;
    m_ill[i] = 0;
    if (!t_en) return;
    cur = exp_pair(i);
    mis = cur[1] && (t_q[i] != cur[0]);
    ill = t_s && t_r;
    m_mis[i] = mis;
    m_ill[i] = ill;
    if (cur[1]) m_chk[i] = (m_chk[i] + 1 > mx) ? mx : m_chk[i] + 1;
    m_err[i] = m_err[i] + int'(mis) + int'(ill);
    if (m_err[i] > mx) m_err[i] = mx;
    if (t_s != t_r) begin
      m_state[i] = 1; m_model[i] = t_s; m_known[i] = 1;
    end else if (ill) begin
      m_known[i] = 0;
      if (m_state[i] == 1) m_state[i] = 2;
    end
    if (RESYNC && mis) begin
      m_model[i] = t_q[i]; m_known[i] = 1;
      for (int k = 0; k < 8; k++) hist[i][k] = {1'b1, t_q[i]};
    end else begin
      hist[i][wp[i] & 7] = {m_known[i], m_model[i]};
      wp[i] = (wp[i] + 1) & 7;
    end
  endtask

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int i, input int eq, input int ev, input int mm,
                            input int il, input int ec, input int cc, input int st);
    bit [1:0] cur;
    cur = exp_pair(i);
    chk("exp_q", i, eq, int'(cur[0]));
    chk("exp_vld", i, ev, int'(cur[1]));
    chk("mismatch", i, mm, int'(m_mis[i]));
    chk("illegal", i, il, int'(m_ill[i]));
    chk("err_cnt", i, ec, m_err[i]);
    chk("chk_cnt", i, cc, m_chk[i]);
    chk("state", i, st, m_state[i]);
  endtask

  // one clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_inst(0, bus_a.exp_q, bus_a.exp_vld, bus_a.mismatch, bus_a.illegal,
               bus_a.err_cnt, bus_a.chk_cnt, bus_a.state);
    check_inst(1, bus_b.exp_q, bus_b.exp_vld, bus_b.mismatch, bus_b.illegal,
               bus_b.err_cnt, bus_b.chk_cnt, bus_b.state);
  endtask

  initial begin
    int sel;
    bit [1:0] ep;

    // reset
    set_in(1, 1, 0, 0, 0, 0);
    cycle();
    chk("rst_exp_vld_a", 0, bus_a.exp_vld, 0);
    chk("rst_chk_cnt_b", 1, bus_b.chk_cnt, 0);
    chk("rst_state_b", 1, bus_b.state, 0);

    // 01 then four 00 edges, q tracking at 0
    set_in(0, 1, 0, 1, 0, 0);
    cycle();
    chk("first_exp_vld_a", 0, bus_a.exp_vld, 1);
    chk("first_exp_q_a", 0, bus_a.exp_q, 0);
    set_in(0, 1, 0, 0, 0, 0);
    repeat (4) cycle();
    chk("track_chk_cnt_a", 0, bus_a.chk_cnt, 4);
    chk("track_err_cnt_a", 0, bus_a.err_cnt, 0);
    chk("track_state_a", 0, bus_a.state, 1);
    chk("track_chk_cnt_b", 1, bus_b.chk_cnt, 2);

    // set while q stays 0: repeated mismatches / saturation on the 2-bit counters
    set_in(0, 1, 1, 0, 0, 0);
    cycle();
    set_in(0, 1, 0, 0, 0, 0);
    cycle();
    chk("div_mismatch_a", 0, bus_a.mismatch, 1);
    repeat (6) cycle();
    chk("div_err_cnt_a", 0, bus_a.err_cnt, RESYNC ? 1 : 7);
    chk("div_chk_cnt_a", 0, bus_a.chk_cnt, 12);
    chk("div_err_cnt_b", 1, bus_b.err_cnt, RESYNC ? 1 : 3);
    chk("div_chk_cnt_b", 1, bus_b.chk_cnt, 3);

    // illegal drive, drain, then recover
    set_in(0, 1, 1, 1, 0, 0);
    cycle();
    chk("ill_pulse_a", 0, bus_a.illegal, 1);
    chk("ill_state_a", 0, bus_a.state, 2);
    chk("ill_exp_vld_a", 0, bus_a.exp_vld, 0);
    set_in(0, 1, 0, 0, 0, 0);
    cycle();
    chk("ill_once_a", 0, bus_a.illegal, 0);
    cycle();
    chk("ill_drain_b", 1, bus_b.exp_vld, 0);
    chk("ill_state_b", 1, bus_b.state, 2);
    set_in(0, 1, 1, 0, 0, 0);
    cycle();
    chk("recover_state_a", 0, bus_a.state, 1);
    chk("recover_state_b", 1, bus_b.state, 1);

    // en low while s/r toggle
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1, (k != 1), 1, 1);
      cycle();
      chk("en0_illegal_a", 0, bus_a.illegal, 0);
      chk("en0_mismatch_b", 1, bus_b.mismatch, 0);
    end

    // fill LAT=3 pipe, then reset mid-stream
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1, k[0], !k[0], 1, 0);
      cycle();
    end
    set_in(1, 1, 1, 0, 1, 1);
    cycle();
    chk("mid_rst_exp_vld_b", 1, bus_b.exp_vld, 0);
    chk("mid_rst_err_cnt_b", 1, bus_b.err_cnt, 0);
    chk("mid_rst_state_b", 1, bus_b.state, 0);
    set_in(0, 1, 0, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("post_rst_mismatch_b", 1, bus_b.mismatch, 0);
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      t_rst = ($urandom_range(0, 99) == 0);
      t_en  = ($urandom_range(0, 99) < 85);
      sel   = $urandom_range(0, 7);
      t_s   = (sel == 3) || (sel >= 6);
      t_r   = (sel == 3) || (sel == 4) || (sel == 5);
      for (int i = 0; i < 2; i++) begin
        ep = exp_pair(i);
        t_q[i] = ($urandom_range(0, 9) == 0) ? bit'($urandom_range(0, 1)) : ep[0];
      end
      drive();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
